// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mips_pkg                                                     |
// | Shared MEM-stage types: FSM state encoding, link register index and   |
// | sub-word load type decode.                                             |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package mips_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_e;

   localparam logic [4:0] REG_LINK = 5'd31;

   typedef enum logic [2:0] {
      LD_WORD = 3'd0,
      LD_BU   = 3'd1,
      LD_BS   = 3'd2,
      LD_HU   = 3'd3,
      LD_HS   = 3'd4
   } load_type_e;

   // The flags are one-hot (or all clear for a full word); a fixed priority
   // keeps the decode well defined should more than one ever be set.
   function automatic load_type_e decode_load_type(
      input logic lhu,
      input logic lhs,
      input logic lbu,
      input logic lbs
   );
      if (lbs)      return LD_BS;
      else if (lbu) return LD_BU;
      else if (lhs) return LD_HS;
      else if (lhu) return LD_HU;
      else          return LD_WORD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mem_access_stage_if                                        |
// | Request/acknowledge data-memory bus between the MEM stage (master)     |
// | and the data memory (slave).                                           |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface mem_access_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_load_extract.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : load_extract                                                 |
// | Big-endian byte/halfword lane select with sign or zero extension.      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module load_extract
   import mips_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        lhunsigned_i,
   input  logic        lhsigned_i,
   input  logic        lbunsigned_i,
   input  logic        lbsigned_i,
   output logic [31:0] data_o
);

   load_type_e w_type;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_type = decode_load_type(lhunsigned_i, lhsigned_i, lbunsigned_i, lbsigned_i);

   // Lane select: byte 0 is the most significant byte of the word.
   always_comb begin
      w_byte = rdata_i[31:24];
      case (addr_lo_i)
         2'd0:    w_byte = rdata_i[31:24];
         2'd1:    w_byte = rdata_i[23:16];
         2'd2:    w_byte = rdata_i[15:8];
         default: w_byte = rdata_i[7:0];
      endcase
      w_half = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
   end

   // Extension according to the decoded load type.
   always_comb begin
      data_o = rdata_i;
      case (w_type)
         LD_BU:   data_o = {24'd0, w_byte};
         LD_BS:   data_o = {{24{w_byte[7]}}, w_byte};
         LD_HU:   data_o = {16'd0, w_half};
         LD_HS:   data_o = {{16{w_half[15]}}, w_half};
         default: data_o = rdata_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_access_stage                                             |
// | MIPS MEM stage: data-memory req/ack transaction with timeout, pipeline |
// | stall, sub-word load extraction and MEM/WB register.                   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module mem_access_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] O_outEXMEM,
   input  logic [31:0] o_RT_DataEXMEM,
   input  logic        re_inEXMEM,
   input  logic        we_inEXMEM,
   input  logic [4:0]  reg2EXMEM,
   input  logic [4:0]  reg3EXMEM,
   input  logic        mux1SelectEXMEM,
   input  logic        linkRegEXMEM,
   input  logic [31:0] pcPlus4EXMEM,
   input  logic        i_Write_EnableEXMEM,
   input  logic        lhunsigned_outEXMEM,
   input  logic        lhsigned_outEXMEM,
   input  logic        lbunsigned_outEXMEM,
   input  logic        lbsigned_outEXMEM,
   mem_access_stage_if.master mem_bus,
   output logic        stall,
   output logic        mem_err,
   output logic [31:0] wb_dataMEMWB,
   output logic [4:0]  wb_regMEMWB,
   output logic        wb_weMEMWB
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic [4:0]        wb_reg_q, wb_reg_d;
   logic              wb_we_q, wb_we_d;

   logic              w_mem_op;
   logic [4:0]        w_dest;
   logic [31:0]       w_load_data;

   assign w_mem_op = re_inEXMEM | we_inEXMEM;
   assign w_dest   = linkRegEXMEM ? REG_LINK : (mux1SelectEXMEM ? reg3EXMEM : reg2EXMEM);

   // The low address bits are latched with the request; the type flags are
   // taken live because the EX/MEM register is held for the whole access.
   load_extract u_load_extract (
      .rdata_i      (mem_bus.mem_rdata),
      .addr_lo_i    (addr_lo_q),
      .lhunsigned_i (lhunsigned_outEXMEM),
      .lhsigned_i   (lhsigned_outEXMEM),
      .lbunsigned_i (lbunsigned_outEXMEM),
      .lbsigned_i   (lbsigned_outEXMEM),
      .data_o       (w_load_data)
   );

   // Next-state, bus and MEM/WB decode; MEM/WB defaults to a bubble.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      addr_lo_d = addr_lo_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      wb_data_d = wb_data_q;
      wb_reg_d  = wb_reg_q;
      wb_we_d   = 1'b0;
      stall     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_mem_op) begin
               stall     = 1'b1;
               state_d   = ST_ACCESS;
               req_d     = 1'b1;
               we_d      = we_inEXMEM;
               addr_d    = {O_outEXMEM[31:2], 2'b00};
               addr_lo_d = O_outEXMEM[1:0];
               wdata_d   = o_RT_DataEXMEM;
               cnt_d     = '0;
            end else begin
               wb_data_d = linkRegEXMEM ? pcPlus4EXMEM : O_outEXMEM;
               wb_reg_d  = w_dest;
               wb_we_d   = i_Write_EnableEXMEM;
            end
         end
         ST_ACCESS: begin
            if (mem_bus.mem_ack) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               if (!we_q) begin
                  wb_data_d = w_load_data;
                  wb_reg_d  = w_dest;
                  wb_we_d   = i_Write_EnableEXMEM;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, bus and MEM/WB registers; reset abandons any open transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         addr_lo_q <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         wb_data_q <= '0;
         wb_reg_q  <= '0;
         wb_we_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         addr_lo_q <= addr_lo_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         wb_data_q <= wb_data_d;
         wb_reg_q  <= wb_reg_d;
         wb_we_q   <= wb_we_d;
      end
   end

   assign mem_bus.mem_req   = req_q;
   assign mem_bus.mem_we    = we_q;
   assign mem_bus.mem_addr  = addr_q;
   assign mem_bus.mem_wdata = wdata_q;
   assign mem_err           = err_q;
   assign wb_dataMEMWB      = wb_data_q;
   assign wb_regMEMWB       = wb_reg_q;
   assign wb_weMEMWB        = wb_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mem_access_stage                                          |
// | Directed scoreboard bench for the MEM stage.                           |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_mem_access_stage;

   logic        clock;
   logic        reset;
   logic [31:0] O_outEXMEM, o_RT_DataEXMEM, pcPlus4EXMEM;
   logic        re_inEXMEM, we_inEXMEM, mux1SelectEXMEM, linkRegEXMEM, i_Write_EnableEXMEM;
   logic [4:0]  reg2EXMEM, reg3EXMEM;
   logic        lhu, lhs, lbu, lbs;
   logic        stall, mem_err, wb_weMEMWB;
   logic [31:0] wb_dataMEMWB;
   logic [4:0]  wb_regMEMWB;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
      .clock               (clock),
      .reset               (reset),
      .O_outEXMEM          (O_outEXMEM),
      .o_RT_DataEXMEM      (o_RT_DataEXMEM),
      .re_inEXMEM          (re_inEXMEM),
      .we_inEXMEM          (we_inEXMEM),
      .reg2EXMEM           (reg2EXMEM),
      .reg3EXMEM           (reg3EXMEM),
      .mux1SelectEXMEM     (mux1SelectEXMEM),
      .linkRegEXMEM        (linkRegEXMEM),
      .pcPlus4EXMEM        (pcPlus4EXMEM),
      .i_Write_EnableEXMEM (i_Write_EnableEXMEM),
      .lhunsigned_outEXMEM (lhu),
      .lhsigned_outEXMEM   (lhs),
      .lbunsigned_outEXMEM (lbu),
      .lbsigned_outEXMEM   (lbs),
      .mem_bus             (bus.master),
      .stall               (stall),
      .mem_err             (mem_err),
      .wb_dataMEMWB        (wb_dataMEMWB),
      .wb_regMEMWB         (wb_regMEMWB),
      .wb_weMEMWB          (wb_weMEMWB)
   );

   typedef struct packed { logic [31:0] data; logic [4:0] rg; } wb_t;
   typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } mr_t;

   wb_t wb_q[$];
   mr_t mr_q[$];
   mr_t cur_mr;
   logic prev_req;
   int tests;
   int fails;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Writeback monitor: every enabled MEM/WB write must match the next expected entry.
   always @(negedge clock) begin
      wb_t e;
      if (wb_weMEMWB === 1'b1) begin
         if (wb_q.size() == 0) begin
            check("wb_unexpected_write", 32'd1, 32'd0);
         end else begin
            e = wb_q.pop_front();
            check("wb_data", wb_dataMEMWB, e.data);
            check("wb_reg", {27'd0, wb_regMEMWB}, {27'd0, e.rg});
         end
      end
   end

   // Bus monitor: each new request is matched, and held stable until it ends.
   initial prev_req = 1'b0;
   always @(negedge clock) begin
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) begin
         if (mr_q.size() == 0) check("mem_unexpected_req", 32'd1, 32'd0);
         else cur_mr = mr_q.pop_front();
      end
      if (bus.mem_req === 1'b1) begin
         check("mem_addr", bus.mem_addr, cur_mr.addr);
         check("mem_we", {31'd0, bus.mem_we}, {31'd0, cur_mr.we});
         check("mem_wdata", bus.mem_wdata, cur_mr.wdata);
      end
      prev_req = bus.mem_req;
   end

   task automatic idle_inputs();
      O_outEXMEM = 32'h0; o_RT_DataEXMEM = 32'h0; pcPlus4EXMEM = 32'h0;
      re_inEXMEM = 1'b0; we_inEXMEM = 1'b0; mux1SelectEXMEM = 1'b0; linkRegEXMEM = 1'b0;
      i_Write_EnableEXMEM = 1'b0; reg2EXMEM = 5'd0; reg3EXMEM = 5'd0;
      lhu = 1'b0; lhs = 1'b0; lbu = 1'b0; lbs = 1'b0;
   endtask

   // Memory model + driver for one held EX/MEM memory op. ack_after is the number
   // of ACCESS cycles without ack before the ack cycle (-1: never ack).
   task automatic run_mem(input int ack_after, input logic [31:0] rdata,
                          output int stall_cnt, output int req_cnt, output int err_cnt,
                          output logic wb_we_after);
      int  acc;
      bit  done;
      acc = 0; done = 0; stall_cnt = 0; req_cnt = 0; err_cnt = 0; wb_we_after = 1'b0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         if (bus.mem_req === 1'b1) begin
            req_cnt++;
            if (acc == ack_after) begin
               bus.mem_ack = 1'b1;
               bus.mem_rdata = rdata;
            end
            acc++;
         end
         #1;
         if (stall === 1'b1) stall_cnt++;
         else if (cyc > 0) done = 1;
         @(posedge clock); #1;
         bus.mem_ack = 1'b0;
         if (mem_err === 1'b1) err_cnt++;
         if (done) begin
            wb_we_after = wb_weMEMWB;
            idle_inputs();
         end
      end
      if (!done) begin
         check("run_mem_cycle_bound", 32'd0, 32'd1);
         idle_inputs();
      end
      @(posedge clock); #1;
      if (mem_err === 1'b1) err_cnt++;
   endtask

   initial begin
      int   sc, rc, ec;
      logic wa;
      tests = 0; fails = 0;
      reset = 1'b1;
      idle_inputs();
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      repeat (2) @(posedge clock); #1;
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_mem_err", {31'd0, mem_err}, 32'd0);
      check("rst_wb_data", wb_dataMEMWB, 32'd0);
      check("rst_wb_reg_we", {26'd0, wb_regMEMWB, wb_weMEMWB}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Non-memory ALU op to rd.
      O_outEXMEM = 32'h0000_1234; reg3EXMEM = 5'd7; mux1SelectEXMEM = 1'b1; i_Write_EnableEXMEM = 1'b1;
      wb_q.push_back('{data: 32'h0000_1234, rg: 5'd7});
      #1; check("alu_stall", {31'd0, stall}, 32'd0);
      @(posedge clock); #1;
      check("alu_wb_we", {31'd0, wb_weMEMWB}, 32'd1);
      idle_inputs();

      // lb signed, lane 2, ack on the 4th ACCESS cycle (counter at its last value).
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0102; o_RT_DataEXMEM = 32'h5A5A_0001;
      lbs = 1'b1; reg2EXMEM = 5'd9; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0100, we: 1'b0, wdata: 32'h5A5A_0001});
      wb_q.push_back('{data: 32'hFFFF_FF83, rg: 5'd9});
      run_mem(3, 32'h1122_8344, sc, rc, ec, wa);
      check("lbs_stall_cycles", sc, 4);
      check("lbs_wb_we_after_ack", {31'd0, wa}, 32'd1);
      check("lbs_no_err", ec, 0);

      // lh unsigned, immediate ack: two-cycle latency.
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0102; lhu = 1'b1; reg2EXMEM = 5'd9; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0100, we: 1'b0, wdata: 32'h0});
      wb_q.push_back('{data: 32'h0000_8001, rg: 5'd9});
      run_mem(0, 32'hAAAA_8001, sc, rc, ec, wa);
      check("lhu_stall_cycles", sc, 1);
      check("lhu_wb_we_after_ack", {31'd0, wa}, 32'd1);

      // lh signed, upper half, to rd.
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0100; lhs = 1'b1; reg3EXMEM = 5'd12;
      mux1SelectEXMEM = 1'b1; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0100, we: 1'b0, wdata: 32'h0});
      wb_q.push_back('{data: 32'hFFFF_8001, rg: 5'd12});
      run_mem(1, 32'h8001_0000, sc, rc, ec, wa);
      check("lhs_stall_cycles", sc, 2);

      // lb unsigned lane 1 with link set: load data wins, destination is r31.
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0001; lbu = 1'b1; linkRegEXMEM = 1'b1;
      pcPlus4EXMEM = 32'h0000_0444; reg2EXMEM = 5'd4; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0000, we: 1'b0, wdata: 32'h0});
      wb_q.push_back('{data: 32'h0000_00F4, rg: 5'd31});
      run_mem(0, 32'h12F4_5678, sc, rc, ec, wa);

      // Full word load, misaligned low bits ignored.
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0007; reg2EXMEM = 5'd3; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0004, we: 1'b0, wdata: 32'h0});
      wb_q.push_back('{data: 32'h89AB_CDEF, rg: 5'd3});
      run_mem(0, 32'h89AB_CDEF, sc, rc, ec, wa);

      // Store: word-aligned address, data held until ack, no writeback.
      we_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0023; o_RT_DataEXMEM = 32'hDEAD_BEEF; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0020, we: 1'b1, wdata: 32'hDEAD_BEEF});
      run_mem(2, 32'h0, sc, rc, ec, wa);
      check("store_stall_cycles", sc, 3);
      check("store_wb_we", {31'd0, wa}, 32'd0);

      // Timeout: no ack ever.
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0040; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0040, we: 1'b0, wdata: 32'h0});
      run_mem(-1, 32'h0, sc, rc, ec, wa);
      check("to_req_cycles", rc, 4);
      check("to_stall_cycles", sc, 4);
      check("to_err_pulses", ec, 1);
      check("to_wb_we", {31'd0, wa}, 32'd0);
      // Late ack in IDLE is ignored.
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
      check("late_ack_req", {31'd0, bus.mem_req}, 32'd0);
      check("late_ack_err", {31'd0, mem_err}, 32'd0);
      check("late_ack_stall", {31'd0, stall}, 32'd0);

      // Reset during the second ACCESS cycle.
      re_inEXMEM = 1'b1; O_outEXMEM = 32'h0000_0080; i_Write_EnableEXMEM = 1'b1;
      mr_q.push_back('{addr: 32'h0000_0080, we: 1'b0, wdata: 32'h0});
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
      check("mid_rst_wb_data", wb_dataMEMWB, 32'd0);
      check("mid_rst_wb_reg_we", {26'd0, wb_regMEMWB, wb_weMEMWB}, 32'd0);
      idle_inputs();
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      // Link op after reset.
      linkRegEXMEM = 1'b1; pcPlus4EXMEM = 32'h0000_0040; O_outEXMEM = 32'h0000_5555;
      reg3EXMEM = 5'd6; mux1SelectEXMEM = 1'b1; i_Write_EnableEXMEM = 1'b1;
      wb_q.push_back('{data: 32'h0000_0040, rg: 5'd31});
      #1; check("link_stall", {31'd0, stall}, 32'd0);
      @(posedge clock); #1;
      idle_inputs();
      repeat (3) @(posedge clock);
      #1;
      check("wb_queue_drained", wb_q.size(), 32'd0);
      check("mem_queue_drained", mr_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage consumer of the EX/MEM pipeline register in the 5-stage MIPS core. Decodes the registered EX/MEM fields and runs a request/acknowledge transaction to the data memory for loads and stores, stalling upstream stages until the transaction completes. Extracts and sign- or zero-extends sub-word loads, resolves the writeback destination and data, and registers the MEM/WB outputs. A timeout counter aborts a transaction that never receives an acknowledge.

Parameters:
TIMEOUT, 16, max cycles in ACCESS awaiting mem_ack before abort (>=1)
CNT_W, 5, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
O_outEXMEM  in  32  ALU result / memory byte address
o_RT_DataEXMEM  in  32  store data
re_inEXMEM  in  1  load request
we_inEXMEM  in  1  store request
reg2EXMEM  in  5  rt destination
reg3EXMEM  in  5  rd destination
mux1SelectEXMEM  in  1  1=dest reg3, 0=dest reg2
linkRegEXMEM  in  1  link op: dest=31, data=pcPlus4
pcPlus4EXMEM  in  32  link value
i_Write_EnableEXMEM  in  1  register-file write request
lhunsigned_outEXMEM, lhsigned_outEXMEM, lbunsigned_outEXMEM, lbsigned_outEXMEM  in  1 each  sub-word load type (one-hot or none = word)
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  store data
mem_ack  in  1  single-cycle completion strobe
mem_rdata  in  32  read data, valid with mem_ack
stall  out  1  hold PC/IFID/IDEX/EXMEM (combinational)
mem_err  out  1  one-cycle pulse on timeout
wb_dataMEMWB  out  32  writeback data
wb_regMEMWB  out  5  writeback register
wb_weMEMWB  out  1  writeback enable

Behaviour:
- Reset (async): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, counter, mem_err, wb_dataMEMWB, wb_regMEMWB, wb_weMEMWB all 0.
- States: IDLE, ACCESS.
- IDLE with re|we:
  - stall=1; at the clock edge latch addr, wdata, mem_we=we (we wins if both set); assert mem_req; counter=0; go ACCESS.
  - MEM/WB receives a bubble at that edge (wb_weMEMWB=0).
- IDLE without re|we: stall=0; at the clock edge MEM/WB registers the ALU/link result. Latency 1 cycle.
- ACCESS without mem_ack:
  - stall=1; mem_req, mem_addr, mem_we, mem_wdata stable; counter++; MEM/WB bubble.
- ACCESS with mem_ack:
  - stall=0. At the clock edge: mem_req=0, go IDLE; MEM/WB registers the load result (re) or a bubble (store).
  - The EX/MEM inputs still hold the same op during this cycle, so decode uses live inputs.
  - Minimum load latency: 2 cycles from op presentation.
- ACCESS with counter==TIMEOUT-1 and no ack:
  - stall=0; at the clock edge mem_req=0, mem_err=1 for 1 cycle, MEM/WB bubble, go IDLE.
  - An ack arriving after the abort is ignored.
- Ack in IDLE: ignored.
- Destination: link ? 31 : (mux1Select ? reg3 : reg2).
- Data priority: load extract > link pcPlus4 > O_out.
- wb_weMEMWB = i_Write_Enable on non-bubble cycles.
- Big-endian extraction from mem_rdata using latched addr:
  - Byte lane: a[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Halfword: a[1]=0 -> [31:16], else [15:0]; a[0] ignored.
  - Signed forms sign-extend to 32 bits; unsigned forms zero-extend.
  - No sub-word flag set: full word; a[1:0] ignored.
- Stores are word-only; there are no byte enables.
- Reset mid-ACCESS: mem_req drops immediately and the transaction is abandoned.

Decomposition:
- Shared package mips_pkg: state encoding, REG_LINK=5'd31, load-type encoding.
- One sub-module, load_extract: combinational, takes (rdata, addr[1:0], 4 type flags) and returns 32-bit extended data.
- FSM, timeout counter and MEM/WB registers stay in the top block.

Test Plan:
- Non-mem op: O_out=0x0000_1234, reg3=7, mux1=1, WE=1 -> next edge wb_data=0x1234, wb_reg=7, wb_we=1, stall never high.
- Load, 3-cycle ack latency, addr=0x102, lbsigned, rdata=0x11228344 -> stall high 4 cycles; wb_data=0xFFFFFF83 with wb_we=1 the edge after ack.
- Load, ack 1 cycle after req, lhunsigned, addr=0x102, rdata=0xAAAA8001 -> wb_data=0x00008001; total latency 2 cycles.
- Store o_RT_Data=0xDEADBEEF, addr=0x23 -> mem_addr=0x20, mem_we=1, mem_wdata=0xDEADBEEF held until ack; wb_we=0.
- No ack with TIMEOUT=4 -> mem_req high 4 cycles, mem_err pulses once, stall drops, a late ack has no effect.
- Assert reset in ACCESS cycle 2 -> mem_req=0 and all MEM/WB outputs 0 immediately; a link op with pcPlus4=0x40 afterwards gives wb_reg=31, wb_data=0x40.
